// File: rtl/ktms_mmwr_ctxt_regfile.sv
// Per-context config/doorbell register file fed by decoded MMIO writes.
// Clears all contexts after reset, then stores writes and raises doorbell events.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping init_val into both arrays, one context per cycle
// ST_RUN  | accepting writes, emitting doorbells, serving reads
module ktms_mmwr_ctxt_regfile #(
    parameter int unsigned ctxtid_width  = 10,
    parameter int unsigned lcladdr_width = 1,
    parameter logic [63:0] init_val      = 64'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_v,
    output logic                     i_wr_r,
    input  logic [lcladdr_width-1:0] i_wr_addr,
    input  logic [ctxtid_width-1:0]  i_wr_ctxt,
    input  logic [63:0]              i_wr_d,
    input  logic                     i_rd_v,
    input  logic [ctxtid_width-2:0]  i_rd_ctxt,
    output logic [63:0]              o_rd_cfg,
    output logic [63:0]              o_rd_db,
    output logic                     o_db_v,
    input  logic                     o_db_r,
    output logic [ctxtid_width-2:0]  o_db_ctxt,
    output logic [31:0]              o_db_d,
    output logic                     o_perror,
    output logic                     o_init_done
);

    localparam int unsigned IW    = ctxtid_width - 1;
    localparam int unsigned NCTXT = 1 << IW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            cnt_q, cnt_d;
    logic                     run;
    logic                     init_we;

    logic                     stg_v_q, stg_v_d;
    logic [lcladdr_width-1:0] stg_addr_q, stg_addr_d;
    logic [IW-1:0]            stg_idx_q, stg_idx_d;
    logic [63:0]              stg_d_q, stg_d_d;
    logic                     perr_q, perr_d;

    logic                     db_v_q, db_v_d;
    logic [IW-1:0]            db_ctxt_q, db_ctxt_d;
    logic [31:0]              db_d_q, db_d_d;

    logic [63:0]              rd_cfg_q, rd_cfg_d;
    logic [63:0]              rd_db_q, rd_db_d;

    logic [63:0]              cfg_mem [NCTXT];
    logic [63:0]              db_mem  [NCTXT];

    logic                     wr_acc;
    logic                     par_ok;
    logic                     stg_is_cfg;
    logic                     stg_is_db;
    logic                     stg_stall;
    logic                     stg_go;
    logic                     cfg_we;
    logic                     db_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run     = 1'b0;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = ~reset;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IW'(NCTXT - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Only a pending, unaccepted doorbell can stall the upstream.
    assign i_wr_r = run & ~(db_v_q & ~o_db_r);
    assign wr_acc = i_wr_v & i_wr_r;
    assign par_ok = ^i_wr_ctxt;

    assign stg_is_cfg = (stg_addr_q == '0);
    assign stg_is_db  = (stg_addr_q == lcladdr_width'(1));

    // A staged doorbell write waits while the previous event is still unaccepted;
    // i_wr_r is low for exactly those cycles, so nothing can overrun the stage.
    assign stg_stall = stg_v_q & stg_is_db & db_v_q & ~o_db_r;
    assign stg_go    = stg_v_q & ~stg_stall & ~reset;
    assign cfg_we    = stg_go & stg_is_cfg;
    assign db_we     = stg_go & stg_is_db;

    always_comb begin
        stg_v_d    = stg_v_q & stg_stall;
        stg_addr_d = stg_addr_q;
        stg_idx_d  = stg_idx_q;
        stg_d_d    = stg_d_q;
        perr_d     = wr_acc & ~par_ok;
        if (wr_acc) begin
            stg_v_d    = par_ok;
            stg_addr_d = i_wr_addr;
            stg_idx_d  = i_wr_ctxt[ctxtid_width-1:1];
            stg_d_d    = i_wr_d;
        end
    end

    always_comb begin
        db_v_d    = db_v_q & ~o_db_r;
        db_ctxt_d = db_ctxt_q;
        db_d_d    = db_d_q;
        if (db_we) begin
            db_v_d    = 1'b1;
            db_ctxt_d = stg_idx_q;
            db_d_d    = stg_d_q[31:0];
        end
    end

    always_comb begin
        rd_cfg_d = rd_cfg_q;
        rd_db_d  = rd_db_q;
        if (i_rd_v) begin
            rd_cfg_d = run ? cfg_mem[i_rd_ctxt] : '0;
            rd_db_d  = run ? db_mem[i_rd_ctxt]  : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_v_q  <= 1'b0;
            perr_q   <= 1'b0;
            db_v_q   <= 1'b0;
            rd_cfg_q <= '0;
            rd_db_q  <= '0;
        end else begin
            stg_v_q  <= stg_v_d;
            perr_q   <= perr_d;
            db_v_q   <= db_v_d;
            rd_cfg_q <= rd_cfg_d;
            rd_db_q  <= rd_db_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_ctxt_q <= '0;
            db_d_q    <= '0;
        end else begin
            db_ctxt_q <= db_ctxt_d;
            db_d_q    <= db_d_d;
        end
    end

    // Stage payload needs no reset: it is qualified by stg_v_q.
    always_ff @(posedge clk) begin
        stg_addr_q <= stg_addr_d;
        stg_idx_q  <= stg_idx_d;
        stg_d_q    <= stg_d_d;
    end

    // Arrays have no reset; the INIT sweep defines their contents.
    always_ff @(posedge clk) begin
        if (init_we) begin
            cfg_mem[cnt_q] <= init_val;
            db_mem[cnt_q]  <= init_val;
        end else begin
            if (cfg_we) begin
                cfg_mem[stg_idx_q] <= stg_d_q;
            end
            if (db_we) begin
                db_mem[stg_idx_q] <= stg_d_q;
            end
        end
    end

    assign o_rd_cfg    = rd_cfg_q;
    assign o_rd_db     = rd_db_q;
    assign o_db_v      = db_v_q;
    assign o_db_ctxt   = db_ctxt_q;
    assign o_db_d      = db_d_q;
    assign o_perror    = perr_q;
    assign o_init_done = run;

endmodule

// File: tb/tb_ktms_mmwr_ctxt_regfile.sv
// Scoreboard bench for ktms_mmwr_ctxt_regfile: stimulus pushes expectations,
// a negedge monitor pops them when reads, doorbells or parity errors appear.
module tb_ktms_mmwr_ctxt_regfile;

    localparam int CW = 10;
    localparam int IW = 9;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_wr_v;
    logic          i_wr_r;
    logic [0:0]    i_wr_addr;
    logic [CW-1:0] i_wr_ctxt;
    logic [63:0]   i_wr_d;
    logic          i_rd_v;
    logic [IW-1:0] i_rd_ctxt;
    logic [63:0]   o_rd_cfg;
    logic [63:0]   o_rd_db;
    logic          o_db_v;
    logic          o_db_r;
    logic [IW-1:0] o_db_ctxt;
    logic [31:0]   o_db_d;
    logic          o_perror;
    logic          o_init_done;

    int total = 0;
    int bad   = 0;

    logic [127:0]  rd_q[$];
    logic [IW+31:0] db_q[$];
    bit            perr_q[$];
    logic [63:0]   cfg_m[N];
    logic [63:0]   db_m[N];
    logic          rd_pend = 1'b0;

    ktms_mmwr_ctxt_regfile #(
        .ctxtid_width (CW),
        .lcladdr_width(1),
        .init_val     (64'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wr_v     (i_wr_v),
        .i_wr_r     (i_wr_r),
        .i_wr_addr  (i_wr_addr),
        .i_wr_ctxt  (i_wr_ctxt),
        .i_wr_d     (i_wr_d),
        .i_rd_v     (i_rd_v),
        .i_rd_ctxt  (i_rd_ctxt),
        .o_rd_cfg   (o_rd_cfg),
        .o_rd_db    (o_rd_db),
        .o_db_v     (o_db_v),
        .o_db_r     (o_db_r),
        .o_db_ctxt  (o_db_ctxt),
        .o_db_d     (o_db_d),
        .o_perror   (o_perror),
        .o_init_done(o_init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_pend <= i_rd_v;

    // Monitor: every observable event must match the head of its queue.
    always @(negedge clk) begin
        logic [127:0]   re;
        logic [IW+31:0] de;
        if (rd_pend) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got cfg=%h db=%h with no read pending", o_rd_cfg, o_rd_db);
            end else begin
                re = rd_q.pop_front();
                if ({o_rd_cfg, o_rd_db} !== re) begin
                    bad++;
                    $display("FAIL rd_data: got cfg=%h db=%h expected cfg=%h db=%h",
                             o_rd_cfg, o_rd_db, re[127:64], re[63:0]);
                end
            end
        end
        if (o_db_v === 1'b1 && o_db_r === 1'b1) begin
            total++;
            if (db_q.size() == 0) begin
                bad++;
                $display("FAIL db_unexpected: got ctxt=%0h d=%h", o_db_ctxt, o_db_d);
            end else begin
                de = db_q.pop_front();
                if ({o_db_ctxt, o_db_d} !== de) begin
                    bad++;
                    $display("FAIL db_event: got ctxt=%0h d=%h expected ctxt=%0h d=%h",
                             o_db_ctxt, o_db_d, de[IW+31:32], de[31:0]);
                end
            end
        end
        if (o_perror === 1'b1) begin
            total++;
            if (perr_q.size() == 0) begin
                bad++;
                $display("FAIL perror_unexpected: got 1 expected 0");
            end else begin
                void'(perr_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int idx, input bit good, input logic [0:0] addr,
                      input logic [63:0] d, output int waits);
        logic [IW-1:0] ix;
        logic          p;
        bit            acc;
        ix = idx[IW-1:0];
        p  = good ? ~(^ix) : (^ix);
        i_wr_v    = 1'b1;
        i_wr_ctxt = {ix, p};
        i_wr_addr = addr;
        i_wr_d    = d;
        waits     = 0;
        acc       = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            if (i_wr_r === 1'b1) acc = 1'b1;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        i_wr_v = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL wr_timeout: got no ready for ctxt %0d expected accept", idx);
        end else if (!good) begin
            perr_q.push_back(1'b1);
        end else if (addr == 1'b0) begin
            cfg_m[ix] = d;
        end else begin
            db_m[ix] = d;
            db_q.push_back({ix, d[31:0]});
        end
    endtask

    task automatic rd(input int idx, input logic [63:0] ecfg, input logic [63:0] edb);
        i_rd_v    = 1'b1;
        i_rd_ctxt = idx[IW-1:0];
        rd_q.push_back({ecfg, edb});
        @(posedge clk);
        #1;
        i_rd_v = 1'b0;
    endtask

    task automatic rdm(input int idx);
        rd(idx, cfg_m[idx], db_m[idx]);
    endtask

    task automatic reset_sweep(input int hold);
        int err;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_q.delete();
        db_q.delete();
        perr_q.delete();
        for (int i = 0; i < N; i++) begin
            cfg_m[i] = 64'd0;
            db_m[i]  = 64'd0;
        end
        @(posedge clk);
        #1;
        chk("rst_db_v", o_db_v, 0);
        err = 0;
        repeat (hold) begin
            @(negedge clk);
            if (i_wr_r !== 1'b0 || o_init_done !== 1'b0 || o_db_v !== 1'b0 || o_perror !== 1'b0) err++;
        end
        chk("rst_hold", err, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        i_wr_v = 1'b0;
        o_db_r = 1'b1;
        err = 0;
        repeat (N) begin
            @(negedge clk);
            if (i_wr_r !== 1'b0 || o_init_done !== 1'b0 || o_db_v !== 1'b0 || o_perror !== 1'b0) err++;
        end
        chk("init_hold", err, 0);
        @(negedge clk);
        chk("init_done", o_init_done, 1);
        chk("run_wr_r", i_wr_r, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int w2;
        logic [63:0] old_cfg;
        reset     = 1'b1;
        i_wr_v    = 1'b0;
        i_wr_addr = '0;
        i_wr_ctxt = '0;
        i_wr_d    = '0;
        i_rd_v    = 1'b0;
        i_rd_ctxt = '0;
        o_db_r    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_sweep(N);

        rd(9'h1FF, 64'd0, 64'd0);

        wr(5, 1'b1, 1'b0, 64'h1122334455667788, w);
        idle(1);
        rdm(5);
        idle(2);
        chk("rd_hold_cfg", o_rd_cfg, 64'h1122334455667788);
        chk("rd_hold_db", o_rd_db, 64'd0);

        // Read-first collision: read one cycle after accept sees old data.
        old_cfg = cfg_m[5];
        wr(5, 1'b1, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, w);
        rd(5, old_cfg, db_m[5]);
        rdm(5);

        o_db_r = 1'b0;
        wr(7, 1'b1, 1'b1, 64'h00000000DEADBEEF, w);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("db_hold_v", o_db_v, 1);
            chk("db_hold_ctxt", o_db_ctxt, 7);
            chk("db_hold_d", o_db_d, 32'hDEADBEEF);
            chk("db_hold_wr_r", i_wr_r, 0);
        end
        @(posedge clk);
        #1;
        o_db_r = 1'b1;
        @(negedge clk);
        chk("db_accept_wr_r", i_wr_r, 1);
        @(posedge clk);
        #1;
        chk("db_cleared", o_db_v, 0);
        idle(1);
        rdm(7);

        o_db_r = 1'b0;
        wr(10, 1'b1, 1'b1, 64'h0123456789ABCDEF, w);
        wr(11, 1'b1, 1'b1, 64'hFEDCBA9876543210, w2);
        chk("stage_accept_wait", w2, 0);
        @(negedge clk);
        chk("stall_wr_r", i_wr_r, 0);
        chk("stall_db_ctxt", o_db_ctxt, 10);
        idle(3);
        o_db_r = 1'b1;
        idle(4);
        rdm(10);
        rdm(11);

        wr(1, 1'b1, 1'b1, 64'h1111_1111_AAAA_0001, w);
        wr(2, 1'b1, 1'b1, 64'h2222_2222_BBBB_0002, w2);
        chk("b2b_nostall", w2, 0);
        @(negedge clk);
        chk("b2b_ev1", {o_db_v, o_db_ctxt}, {1'b1, 9'd1});
        @(negedge clk);
        chk("b2b_ev2", {o_db_v, o_db_ctxt}, {1'b1, 9'd2});
        @(posedge clk);
        #1;
        idle(2);

        wr(3, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, w);
        idle(2);
        rdm(3);
        idle(2);
        chk("perr_drained", perr_q.size(), 0);

        wr(20, 1'b1, 1'b0, 64'hCAFE_F00D_0000_0014, w);
        o_db_r = 1'b0;
        wr(9, 1'b1, 1'b1, 64'h0000_0000_0000_0909, w);
        idle(2);
        chk("pre_rst_db_v", o_db_v, 1);
        i_wr_v    = 1'b1;
        i_wr_ctxt = {9'd4, 1'b0};
        i_wr_addr = 1'b0;
        i_wr_d    = 64'h4444_4444_4444_4444;
        reset_sweep(20);
        for (int i = 0; i < N; i++) rd(i, 64'd0, 64'd0);

        idle(5);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("db_q_empty", db_q.size(), 0);
        chk("perr_q_empty", perr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ktms_mmwr_ctxt_regfile.md
Name: ktms_mmwr_ctxt_regfile

Overview:
- Consumes decoded multi-context MMIO writes from the MMIO write decoder: valid/ready, context id with trailing parity bit, local address, 64-bit data.
- Stores two 64-bit registers per context in RAM arrays:
  - local addr 0 = ctxt config register;
  - local addr 1 = doorbell register.
- A write to addr 1 also raises a doorbell event toward the command-issue logic.
- Provides a 1-cycle-latency read port used by downstream per-context logic.

Parameters:
- ctxtid_width, 10, context field width including trailing odd-parity bit; number of contexts is 2^(ctxtid_width-1).
- lcladdr_width, 1, local register address width; only values 0 and 1 are decoded.
- init_val, 64'd0, value written to every register during the init sweep.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_wr_v  in  1  write valid
- i_wr_r  out  1  write ready
- i_wr_addr  in  lcladdr_width  local register address
- i_wr_ctxt  in  ctxtid_width  [0:ctxtid_width-2] context index, [ctxtid_width-1] parity
- i_wr_d  in  64  write data
- i_rd_v  in  1  read request
- i_rd_ctxt  in  ctxtid_width-1  read context index
- o_rd_cfg  out  64  config register of context read one cycle earlier
- o_rd_db  out  64  doorbell register of context read one cycle earlier
- o_db_v  out  1  doorbell event valid
- o_db_r  in  1  doorbell event ready
- o_db_ctxt  out  ctxtid_width-1  doorbell context index
- o_db_d  out  32  doorbell payload, equal to write data [32:63]
- o_perror  out  1  one-cycle pulse on context parity error
- o_init_done  out  1  high once the init sweep completes

Behaviour:
- State machine: INIT, then RUN. reset forces INIT with the sweep counter at 0 from any state, including mid-write or with a doorbell pending.
- INIT:
  - One context per cycle; both arrays are written with init_val at the counter index.
  - After index 2^(ctxtid_width-1)-1 is written, next cycle enters RUN.
  - Sweep length is exactly 2^(ctxtid_width-1) cycles.
- Outputs during reset and INIT: i_wr_r=0, o_db_v=0, o_perror=0, o_init_done=0, o_rd_cfg/o_rd_db=0. Read requests in INIT return 0.
- o_init_done rises on the first RUN cycle and stays high until reset.
- i_wr_r in RUN = ~(o_db_v & ~o_db_r). Backpressure applies only while a doorbell is pending and unaccepted.
- A write is accepted when i_wr_v & i_wr_r.
- Parity check: odd parity over the full i_wr_ctxt (index bits plus parity bit) must be 1.
  - On failure: write dropped, no doorbell, o_perror pulses the cycle after acceptance.
  - The handshake still completes, so the upstream is never stalled by bad parity.
- Accepted good write is registered one stage, then written into the array the next cycle.
  - addr 0 writes the cfg array.
  - addr 1 writes the db array and loads the doorbell output register: o_db_v=1, ctxt, i_wr_d[32:63].
  - Other addr values are silently dropped; no perror.
- Doorbell register is 1-deep:
  - Clears when o_db_v & o_db_r.
  - A new doorbell may load in the same cycle as the clear, because i_wr_r was high.
  - o_db_ctxt and o_db_d are held stable while o_db_v=1 and o_db_r=0.
- Read port:
  - Request at cycle t returns o_rd_cfg/o_rd_db at t+1.
  - Outputs hold their last value when i_rd_v=0.
- Same-context write/read collision:
  - A read issued in the same cycle as the array write returns the old value (read-first).
  - A write accepted at t is visible to a read issued at t+2 or later.
- No other internal state; array contents are undefined only before the first INIT completes.

Test Plan:
- Reset, hold 512 cycles: i_wr_r=0 and o_init_done=0 throughout; o_init_done=1 at cycle 512 after reset release. Then read ctxt 0x1FF -> cfg=0, db=0.
- Write ctxt idx 5 (parity 1 to make odd), addr 0, data 0x1122334455667788; read ctxt 5 two cycles later -> o_rd_cfg=0x1122334455667788, o_rd_db=0, no doorbell.
- Write ctxt 7, addr 1, data 0x00000000DEADBEEF with o_db_r=0 -> o_db_v=1, o_db_ctxt=7, o_db_d=0xDEADBEEF held, i_wr_r=0; raise o_db_r -> o_db_v drops next cycle, i_wr_r=1.
- Back-to-back doorbells ctxt 1 then ctxt 2, o_db_r tied 1 -> two consecutive events (1 then 2), no stall cycle.
- Write ctxt 3 with wrong parity bit, addr 0 -> o_perror one-cycle pulse; subsequent read ctxt 3 -> cfg=0.
- Assert reset while o_db_v=1 and writes streaming -> o_db_v=0 next cycle, INIT resweeps 512 cycles, all contexts read back 0.
